// File: rtl/ksa_mp_add_seq.sv
// Multi-precision add/subtract sequencer built around one 32-bit Kogge-Stone adder.
// Operands are processed one 32-bit word per cycle, LSW first, with the carry
// registered between words. The final sum, carry-out and signed overflow are held
// until the consumer takes them.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request; result registers hold the last result
//   RUN     | one word per cycle through ksa32, idx selects the word
//   DONE    | result valid, waiting for out_ready

module ksa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g0;
  logic [31:0] p0;
  logic [31:0] gk;
  logic [31:0] pk;

  // Prefix tree over (generate, propagate); cin is folded into bit 0's generate
  // so the final generate at bit i is the carry into bit i+1.
  always_comb begin
    p0    = a ^ b;
    g0    = a & b;
    g0[0] = g0[0] | (p0[0] & cin);
    gk    = g0;
    pk    = p0;
    for (int k = 0; k < 5; k++) begin
      gk = gk | (pk & (gk << (1 << k)));
      pk = pk & (pk << (1 << k));
    end
    sum  = p0 ^ {gk[30:0], cin};
    cout = gk[31];
  end

endmodule

module ksa_mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op_sub,
  input  logic [32*WORDS-1:0] a,
  input  logic [32*WORDS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*WORDS-1:0] sum,
  output logic                cout,
  output logic                ovf,
  output logic                busy
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [WORDS-1:0][31:0] a_q, a_d;
  logic [WORDS-1:0][31:0] b_q, b_d;
  logic [WORDS-1:0][31:0] sum_q, sum_d;
  logic                   op_sub_q, op_sub_d;
  logic                   carry_q, carry_d;
  logic                   cout_q, cout_d;
  logic                   ovf_q, ovf_d;

  logic [31:0] ksa_a;
  logic [31:0] ksa_b;
  logic [31:0] ksa_sum;
  logic        ksa_cin;
  logic        ksa_cout;
  logic        accept;
  logic        last_word;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign accept    = in_valid & in_ready;
  assign last_word = (idx_q == IDXW'(WORDS - 1));

  // Steer the current word into the adder; operands stay at zero outside RUN.
  always_comb begin
    ksa_a   = '0;
    ksa_b   = '0;
    ksa_cin = 1'b0;
    if (state_q == ST_RUN) begin
      ksa_a   = a_q[idx_q];
      ksa_b   = op_sub_q ? ~b_q[idx_q] : b_q[idx_q];
      ksa_cin = carry_q;
    end
  end

  ksa32 u_ksa32 (
    .a    (ksa_a),
    .b    (ksa_b),
    .cin  (ksa_cin),
    .sum  (ksa_sum),
    .cout (ksa_cout)
  );

  // Sequencer next-state: latch on accept, one word per RUN cycle, hold in DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    op_sub_d = op_sub_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d      = a;
          b_d      = b;
          op_sub_d = op_sub;
          carry_d  = op_sub ? 1'b1 : cin;
          idx_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q] = ksa_sum;
        carry_d      = ksa_cout;
        if (last_word) begin
          idx_d   = '0;
          cout_d  = ksa_cout;
          // ksa_b already carries the inversion for subtract, so its MSB is beff[W-1].
          ovf_d   = (a_q[WORDS-1][31] == ksa_b[31]) & (ksa_sum[31] != a_q[WORDS-1][31]);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      op_sub_q <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      op_sub_q <= op_sub_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ksa_mp_add_seq.sv
// Testbench for ksa_mp_add_seq (WORDS=4): directed cases plus random operations
// compared against a plain wide-arithmetic model.

module tb_ksa_mp_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  ksa_mp_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from unsigned and sign-extended wide arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W:0] u;
    logic [W:0] s;
    logic       c;
    logic       v;
    if (msub) begin
      u = {1'b0, ma} - {1'b0, mb};
      c = (ma >= mb);
      s = {ma[W-1], ma} - {mb[W-1], mb};
    end else begin
      u = {1'b0, ma} + {1'b0, mb} + (W+1)'(mcin);
      c = u[W];
      s = {ma[W-1], ma} + {mb[W-1], mb} + (W+1)'(mcin);
    end
    v = (s[W] != s[W-1]);
    return {v, c, u[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait (bounded) for it to be accepted.
  task automatic issue(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tcin, input logic tsub);
    int n;
    a        = ta;
    b        = tb;
    cin      = tcin;
    op_sub   = tsub;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, W'(in_ready), W'(1'b1));
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, W'(busy), W'(1'b1));
    check({tag, "_noready"}, W'(in_ready), W'(1'b0));
  endtask

  // After an accept edge: wait for out_valid and compare the result.
  task automatic collect(input string tag, input logic [W+1:0] e);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, W'(lat), W'(WORDS));
    check({tag, "_sum"}, sum, e[W-1:0]);
    check({tag, "_cout"}, W'(cout), W'(e[W]));
    check({tag, "_ovf"}, W'(ovf), W'(e[W+1]));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub);
    logic [W+1:0] e;
    e = model(ta, tb, tcin, tsub);
    out_ready = 1'b1;
    issue(tag, ta, tb, tcin, tsub);
    collect(tag, e);
    tick();
    check({tag, "_idle"}, W'(in_ready), W'(1'b1));
    check({tag, "_vlow"}, W'(out_valid), W'(1'b0));
  endtask

  localparam logic [W-1:0] C1_A   = 128'h00000000_00000000_00000000_FFFFFFFF;
  localparam logic [W-1:0] C1_B   = 128'h1;
  localparam logic [W-1:0] ONES   = {W{1'b1}};
  localparam logic [W-1:0] MAXPOS = 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [W-1:0] MINNEG = 128'h80000000_00000000_00000000_00000000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W+1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         stray;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", W'(in_ready), W'(1'b1));
    check("rst_out_valid", W'(out_valid), W'(1'b0));
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_sum", sum, '0);
    check("rst_cout", W'(cout), W'(1'b0));
    check("rst_ovf", W'(ovf), W'(1'b0));

    run_op("c1_carry", C1_A, C1_B, 1'b0, 1'b0);
    run_op("c2_wrap", ONES, '0, 1'b1, 1'b0);
    run_op("c3_borrow", '0, 128'h1, 1'b0, 1'b1);
    run_op("c3_sub", 128'h5, 128'h3, 1'b1, 1'b1);
    run_op("c4_addovf", MAXPOS, 128'h1, 1'b0, 1'b0);
    run_op("c4_subovf", MINNEG, 128'h1, 1'b0, 1'b1);

    // Backpressure: hold the result while a new request waits.
    e = model(ONES, ONES, 1'b1, 1'b0);
    out_ready = 1'b0;
    issue("bp", ONES, ONES, 1'b1, 1'b0);
    collect("bp", e);
    a        = C1_A;
    b        = C1_B;
    cin      = 1'b0;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_hold_valid", W'(out_valid), W'(1'b1));
      check("bp_hold_ready", W'(in_ready), W'(1'b0));
      check("bp_hold_sum", sum, e[W-1:0]);
      check("bp_hold_cout", W'(cout), W'(e[W]));
      check("bp_hold_ovf", W'(ovf), W'(e[W+1]));
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", W'(in_ready), W'(1'b1));
    check("bp_release_valid", W'(out_valid), W'(1'b0));
    tick();
    in_valid = 1'b0;
    check("bp_next_busy", W'(busy), W'(1'b1));
    collect("bp_next", model(C1_A, C1_B, 1'b0, 1'b0));
    tick();

    // Reset in the middle of RUN (idx == 2).
    issue("rstrun", C1_A, C1_B, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrun_ready", W'(in_ready), W'(1'b1));
    check("rstrun_valid", W'(out_valid), W'(1'b0));
    check("rstrun_busy", W'(busy), W'(1'b0));
    check("rstrun_sum", sum, '0);
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) stray = 1'b1;
    end
    check("rstrun_stray", W'(stray), W'(1'b0));
    run_op("rstrun_c1", C1_A, C1_B, 1'b0, 1'b0);

    // Random operations; some operand pairs are biased toward long carry chains.
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: rb = ~ra;
        1: rb = ra;
        default: ;
      endcase
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
